cva6_ptw_walker: RTL

CVA6_PTW_WALKER -- requirements
Module: cva6_ptw_walker

---
 rtl/cva6_ptw_walker.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cva6_ptw_walker.sv
// Sv39 page-table walker: resolves one TLB miss at a time with up to three PTE reads,
// then emits either a single-cycle TLB fill or a single-cycle page-fault pulse.
module cva6_ptw_walker (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        miss_valid_i,
  output logic        miss_ready_o,
  input  logic [38:0] miss_vaddr_i,
  input  logic [15:0] miss_asid_i,
  input  logic [43:0] satp_ppn_i,
  output logic        mem_req_o,
  output logic [55:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i,
  output logic        update_valid_o,
  output logic [1:0]  update_is_page_o,
  output logic [26:0] update_vpn_o,
  output logic [15:0] update_asid_o,
  output logic [63:0] update_content_o,
  output logic        fault_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;

  state_e      state_q;
  logic [1:0]  level_q;
  logic [26:0] vpn_q;
  logic [15:0] asid_q;
  logic [43:0] ppn_q;
  logic        flush_q;

  logic        pte_v;
  logic        pte_r;
  logic        pte_w;
  logic        pte_x;
  logic        pte_leaf;
  logic        pte_misaligned;
  logic        pte_fault;
  logic [43:0] pte_ppn;
  logic [1:0]  next_level;
  logic [1:0]  leaf_page;
  logic [8:0]  cur_vpn;

  // Page-offset bits never take part in a walk.
  logic unused_vaddr_bits;
  assign unused_vaddr_bits = ^miss_vaddr_i[11:0];

  function automatic logic [8:0] vpn_sel(input logic [26:0] vpn, input logic [1:0] lvl);
    case (lvl)
      2'd0:    vpn_sel = vpn[26:18];
      2'd1:    vpn_sel = vpn[17:9];
      default: vpn_sel = vpn[8:0];
    endcase
  endfunction

  always_comb begin
    pte_v          = mem_rdata_i[0];
    pte_r          = mem_rdata_i[1];
    pte_w          = mem_rdata_i[2];
    pte_x          = mem_rdata_i[3];
    pte_ppn        = mem_rdata_i[53:10];
    pte_leaf       = pte_r | pte_x;
    pte_misaligned = 1'b0;
    if (pte_leaf) begin
      if (level_q == 2'd0) begin
        pte_misaligned = |pte_ppn[17:0];
      end else if (level_q == 2'd1) begin
        pte_misaligned = |pte_ppn[8:0];
      end
    end
    pte_fault  = !pte_v || (!pte_r && pte_w) || (!pte_leaf && (level_q == 2'd2)) || pte_misaligned;
    next_level = level_q + 2'd1;
    case (level_q)
      2'd0:    leaf_page = 2'b01;
      2'd1:    leaf_page = 2'b10;
      default: leaf_page = 2'b00;
    endcase
    cur_vpn = vpn_sel(vpn_q, level_q);
  end

  // Address is built purely from latched state, so it cannot move while a request waits for grant.
  assign mem_addr_o   = {ppn_q, cur_vpn, 3'b000};
  assign miss_ready_o = rst_ni && (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      level_q          <= 2'd0;
      vpn_q            <= '0;
      asid_q           <= '0;
      ppn_q            <= '0;
      flush_q          <= 1'b0;
      mem_req_o        <= 1'b0;
      update_valid_o   <= 1'b0;
      update_is_page_o <= 2'b00;
      update_vpn_o     <= '0;
      update_asid_o    <= '0;
      update_content_o <= '0;
      fault_o          <= 1'b0;
    end else begin
      update_valid_o <= 1'b0;
      fault_o        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (miss_valid_i) begin
            vpn_q     <= miss_vaddr_i[38:12];
            asid_q    <= miss_asid_i;
            ppn_q     <= satp_ppn_i;
            level_q   <= 2'd0;
            flush_q   <= 1'b0;
            mem_req_o <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          // A flush cannot withdraw an issued request; remember it and drain the reply instead.
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            flush_q   <= 1'b0;
            state_q   <= (flush_i || flush_q) ? DRAIN : WAIT;
          end else if (flush_i) begin
            flush_q <= 1'b1;
          end
        end
        WAIT: begin
          if (flush_i) begin
            state_q <= mem_rvalid_i ? IDLE : DRAIN;
          end else if (mem_rvalid_i) begin
            if (pte_fault) begin
              fault_o <= 1'b1;
              state_q <= IDLE;
            end else if (pte_leaf) begin
              update_valid_o   <= 1'b1;
              update_is_page_o <= leaf_page;
              update_vpn_o     <= vpn_q;
              update_asid_o    <= asid_q;
              update_content_o <= mem_rdata_i;
              state_q          <= IDLE;
            end else begin
              level_q   <= next_level;
              ppn_q     <= pte_ppn;
              mem_req_o <= 1'b1;
              state_q   <= REQ;
            end
          end
        end
        DRAIN: begin
          if (mem_rvalid_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
